// File: rtl/sort4_sched.sv
// Four-operand in-place bubble sorter: one shared comparator walks a fixed
// six-pair compare-swap schedule, one pair per clock, over a bank of operand registers.
module sort4_sched #(
    parameter int WIDTH   = 6,
    parameter bit DESCEND = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] x0,
    input  logic [WIDTH-1:0] x1,
    input  logic [WIDTH-1:0] x2,
    input  logic [WIDTH-1:0] x3,
    output logic [WIDTH-1:0] s0,
    output logic [WIDTH-1:0] s1,
    output logic [WIDTH-1:0] s2,
    output logic [WIDTH-1:0] s3,
    output logic             busy,
    output logic             done,
    output logic [2:0]       swap_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        CMP,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       step_q, step_d;
    logic [2:0]       swap_cnt_q, swap_cnt_d;
    logic [WIDTH-1:0] r_q [4];
    logic [WIDTH-1:0] r_d [4];
    logic [3:0]       r_en;

    logic [1:0]       idx_a, idx_b;
    logic [WIDTH-1:0] a_val, b_val;
    logic             do_swap;

    // Pair schedule for the six bubble steps; the last pair is (0,1).
    always_comb begin
        idx_a = 2'd0;
        idx_b = 2'd1;
        case (step_q)
            3'd1: begin idx_a = 2'd1; idx_b = 2'd2; end
            3'd2: begin idx_a = 2'd2; idx_b = 2'd3; end
            3'd4: begin idx_a = 2'd1; idx_b = 2'd2; end
            default: begin idx_a = 2'd0; idx_b = 2'd1; end
        endcase
    end

    // Strict unsigned compare: equal operands never swap, keeping the sort stable.
    always_comb begin
        a_val   = r_q[idx_a];
        b_val   = r_q[idx_b];
        do_swap = DESCEND ? (a_val < b_val) : (a_val > b_val);
    end

    always_comb begin
        state_d    = state_q;
        step_d     = step_q;
        swap_cnt_d = swap_cnt_q;
        r_en       = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            r_d[i] = r_q[i];
        end

        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    r_d[0]     = x0;
                    r_d[1]     = x1;
                    r_d[2]     = x2;
                    r_d[3]     = x3;
                    r_en       = 4'b1111;
                    swap_cnt_d = 3'd0;
                    step_d     = 3'd0;
                    state_d    = CMP;
                end
            end
            CMP: begin
                if (do_swap) begin
                    r_d[idx_a]  = b_val;
                    r_d[idx_b]  = a_val;
                    r_en[idx_a] = 1'b1;
                    r_en[idx_b] = 1'b1;
                    swap_cnt_d  = swap_cnt_q + 3'd1;
                end
                if (step_q == 3'd5) begin
                    state_d = DONE;
                end else begin
                    step_d = step_q + 3'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            step_q     <= 3'd0;
            swap_cnt_q <= 3'd0;
            for (int i = 0; i < 4; i++) begin
                r_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            step_q     <= step_d;
            swap_cnt_q <= swap_cnt_d;
            for (int i = 0; i < 4; i++) begin
                if (r_en[i]) begin
                    r_q[i] <= r_d[i];
                end
            end
        end
    end

    assign s0       = r_q[0];
    assign s1       = r_q[1];
    assign s2       = r_q[2];
    assign s3       = r_q[3];
    assign busy     = (state_q == CMP);
    assign done     = (state_q == DONE);
    assign swap_cnt = swap_cnt_q;

endmodule

// File: tb/tb_sort4_sched.sv
// Directed bench for sort4_sched: table of sort vectors plus hand-written
// sequences for mid-sort reset, ignored start during compare, and descending order.
module tb_sort4_sched;

    localparam int W = 6;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start_a = 1'b0;
    logic         start_d = 1'b0;
    logic [W-1:0] x0 = '0, x1 = '0, x2 = '0, x3 = '0;

    logic [W-1:0] a_s0, a_s1, a_s2, a_s3, d_s0, d_s1, d_s2, d_s3;
    logic         a_busy, a_done, d_busy, d_done;
    logic [2:0]   a_cnt, d_cnt;

    logic         sel_desc = 1'b0;
    logic [W-1:0] cur_s0, cur_s1, cur_s2, cur_s3;
    logic         cur_busy, cur_done;
    logic [2:0]   cur_cnt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string        name;
        logic [W-1:0] x0, x1, x2, x3;
        logic [W-1:0] e0, e1, e2, e3;
        logic [2:0]   cnt;
    } vec_t;

    vec_t vecs [4];

    sort4_sched #(.WIDTH(W), .DESCEND(1'b0)) dut_asc (
        .clk(clk), .rst(rst), .start(start_a),
        .x0(x0), .x1(x1), .x2(x2), .x3(x3),
        .s0(a_s0), .s1(a_s1), .s2(a_s2), .s3(a_s3),
        .busy(a_busy), .done(a_done), .swap_cnt(a_cnt)
    );

    sort4_sched #(.WIDTH(W), .DESCEND(1'b1)) dut_desc (
        .clk(clk), .rst(rst), .start(start_d),
        .x0(x0), .x1(x1), .x2(x2), .x3(x3),
        .s0(d_s0), .s1(d_s1), .s2(d_s2), .s3(d_s3),
        .busy(d_busy), .done(d_done), .swap_cnt(d_cnt)
    );

    always #5 clk = ~clk;

    always_comb begin
        cur_s0   = sel_desc ? d_s0   : a_s0;
        cur_s1   = sel_desc ? d_s1   : a_s1;
        cur_s2   = sel_desc ? d_s2   : a_s2;
        cur_s3   = sel_desc ? d_s3   : a_s3;
        cur_busy = sel_desc ? d_busy : a_busy;
        cur_done = sel_desc ? d_done : a_done;
        cur_cnt  = sel_desc ? d_cnt  : a_cnt;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp_v);
        end
    endtask

    task automatic checkResult(input string tag, input logic [W-1:0] e0, input logic [W-1:0] e1,
                               input logic [W-1:0] e2, input logic [W-1:0] e3, input logic [2:0] cnt);
        checkOutput({tag, " s0"}, 32'(cur_s0), 32'(e0));
        checkOutput({tag, " s1"}, 32'(cur_s1), 32'(e1));
        checkOutput({tag, " s2"}, 32'(cur_s2), 32'(e2));
        checkOutput({tag, " s3"}, 32'(cur_s3), 32'(e3));
        checkOutput({tag, " swap_cnt"}, 32'(cur_cnt), 32'(cnt));
    endtask

    task automatic pulseStart(input logic desc, input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic [W-1:0] c, input logic [W-1:0] d);
        @(negedge clk);
        x0 = a; x1 = b; x2 = c; x3 = d;
        if (desc) start_d = 1'b1; else start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        start_d = 1'b0;
    endtask

    // Full sort with a one-cycle start; records busy/done after each of the 7 edges.
    task automatic applyStimulus(input vec_t v, input logic desc);
        logic [6:0] busy_hist;
        logic [6:0] done_hist;
        sel_desc = desc;
        pulseStart(desc, v.x0, v.x1, v.x2, v.x3);
        busy_hist[0] = cur_busy;
        done_hist[0] = cur_done;
        for (int k = 1; k < 7; k++) begin
            @(negedge clk);
            busy_hist[k] = cur_busy;
            done_hist[k] = cur_done;
        end
        checkOutput({v.name, " busy profile"}, 32'(busy_hist), 32'(7'b0111111));
        checkOutput({v.name, " done profile"}, 32'(done_hist), 32'(7'b1000000));
        checkResult(v.name, v.e0, v.e1, v.e2, v.e3, v.cnt);
    endtask

    initial begin
        vecs[0] = '{name: "asc 5,3,7,1",   x0: 5,  x1: 3,  x2: 7,  x3: 1, e0: 1, e1: 3,  e2: 5,  e3: 7,  cnt: 4};
        vecs[1] = '{name: "sorted 1,2,3,4", x0: 1, x1: 2,  x2: 3,  x3: 4, e0: 1, e1: 2,  e2: 3,  e3: 4,  cnt: 0};
        vecs[2] = '{name: "reverse 63..0", x0: 63, x1: 40, x2: 20, x3: 0, e0: 0, e1: 20, e2: 40, e3: 63, cnt: 6};
        vecs[3] = '{name: "dups 9,9,2,9",  x0: 9,  x1: 9,  x2: 2,  x3: 9, e0: 2, e1: 9,  e2: 9,  e3: 9,  cnt: 2};

        @(negedge clk);
        sel_desc = 1'b0;
        checkOutput("reset busy", 32'(a_busy), 0);
        checkOutput("reset done", 32'(a_done), 0);
        checkResult("reset asc", 0, 0, 0, 0, 0);
        sel_desc = 1'b1;
        checkResult("reset desc", 0, 0, 0, 0, 0);
        rst = 1'b0;

        for (int i = 0; i < 4; i++) begin
            applyStimulus(vecs[i], 1'b0);
        end

        // Asynchronous reset after the third compare edge clears everything without a clock.
        sel_desc = 1'b0;
        pulseStart(1'b0, 5, 3, 7, 1);
        repeat (3) @(negedge clk);
        checkOutput("pre-reset busy", 32'(a_busy), 1);
        checkOutput("pre-reset swap_cnt", 32'(a_cnt), 2);
        #1 rst = 1'b1;
        #1;
        checkOutput("mid reset busy", 32'(a_busy), 0);
        checkOutput("mid reset done", 32'(a_done), 0);
        checkResult("mid reset", 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(vecs[0], 1'b0);

        // Start pulsed mid-compare with new operands must not disturb the running sort.
        sel_desc = 1'b0;
        pulseStart(1'b0, 5, 3, 7, 1);
        repeat (2) @(negedge clk);
        x0 = 60; x1 = 50; x2 = 40; x3 = 30;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        checkOutput("ignored start busy", 32'(a_busy), 1);
        repeat (3) @(negedge clk);
        checkOutput("ignored start done", 32'(a_done), 1);
        checkResult("ignored start", 1, 3, 5, 7, 4);
        @(negedge clk);
        checkResult("done hold", 1, 3, 5, 7, 4);

        applyStimulus('{name: "desc 5,3,7,1", x0: 5, x1: 3, x2: 7, x3: 1,
                        e0: 7, e1: 5, e2: 3, e3: 1, cnt: 2}, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sort4_sched.md
Name: sort4_sched

Overview:
Controller that sorts four WIDTH-bit operands in place. It owns a bank of four enable-gated, async-reset operand registers and one shared comparator, and it sequences a fixed 6-step bubble compare-swap schedule, one step per clock. It sits between the board switch/load logic and the display path in the sorting lab datapath. It reports busy, done and a swap count.

Parameters:
WIDTH, 6, operand width in bits
DESCEND, 0, sort order: 0 = ascending (s0 smallest), 1 = descending (s0 largest)

Ports:
clk  input  1  clock, rising-edge
rst  input  1  asynchronous, active-high reset
start  input  1  level-sampled request: load x0..x3 and sort
x0  input  WIDTH  operand 0
x1  input  WIDTH  operand 1
x2  input  WIDTH  operand 2
x3  input  WIDTH  operand 3
s0  output  WIDTH  register 0 contents (result slot 0)
s1  output  WIDTH  register 1 contents
s2  output  WIDTH  register 2 contents
s3  output  WIDTH  register 3 contents
busy  output  1  high while compare steps are in progress
done  output  1  high while a completed result is held
swap_cnt  output  3  number of swaps made in the current or last sort (0..6)

Behaviour:
- Reset: rst is asynchronous, active-high; clock is clk. While rst=1: s0..s3=0, busy=0, done=0, swap_cnt=0, state=IDLE, step=0. Reset asserted mid-sort aborts the sort immediately. No partial result survives.
- States: IDLE, CMP, DONE. busy=1 only in CMP. done=1 only in DONE.
- IDLE or DONE with start=1 at an edge: r0..r3 <= x0..x3, swap_cnt <= 0, step <= 0, next state CMP. With start=0, all state holds.
- CMP: each edge executes the pair for the current step. Step 0..5 pairs: (0,1), (1,2), (2,3), (0,1), (1,2), (0,1).
- Compare rule: unsigned. Ascending swaps when r[a] > r[b]. Descending swaps when r[a] < r[b]. Equal values never swap, so the sort is stable.
- On a swap: both registers of the pair are written in the same edge, and swap_cnt increments. Only the two registers of the active pair get enable. The other two hold.
- Step 5 edge: last swap applied, next state DONE. step does not wrap into a seventh compare.
- Latency: 1 load edge plus 6 compare edges. done rises after the 7th edge counted from the edge that sampled start.
- start during CMP is ignored. x0..x3 changes during CMP are ignored.
- start held high in DONE restarts the sort every time it is sampled. done drops for the 6 CMP cycles.
- Outputs s0..s3 are direct register outputs, with no combinational path from x*. Intermediate values are visible during CMP. Only DONE values are guaranteed sorted.
- swap_cnt saturates naturally at 6. 3 bits suffice.

Test Plan:
- Ascending, x=5,3,7,1, start pulse of 1 cycle -> busy for 6 cycles; done after 7th edge; s=1,3,5,7; swap_cnt=4.
- Already sorted x=1,2,3,4 -> s=1,2,3,4; swap_cnt=0; same 7-edge latency.
- Reverse x=63,40,20,0 -> s=0,20,40,63; swap_cnt=6. Also check 63 is handled unsigned, not treated as negative.
- Duplicates x=9,9,2,9 -> s=2,9,9,9; swap_cnt=2. Check equal pairs never swap.
- Assert rst after the 3rd compare edge -> s0..s3=0, busy=0, done=0, swap_cnt=0 immediately, without waiting for clk. Then start with 5,3,7,1 -> correct full result.
- Pulse start mid-CMP with different x values -> ignored; the original result completes. Then DESCEND=1 instance, x=5,3,7,1 -> s=7,5,3,1; swap_cnt=2.
